// File: rtl/mux_rr_scheduler_if.sv
// Handshake/data bundle between the eight requesters, the shared mux output and the scheduler.
// The master side drives requests, data and downstream ready; the slave (scheduler) returns grant and output.
interface mux_rr_scheduler_if;
  logic [7:0] req;
  logic [7:0] din;
  logic       out_ready;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       y_valid;
  logic       busy;

  modport master (
    output req, din, out_ready,
    input  gnt, sel, y, y_valid, busy
  );

  modport slave (
    input  req, din, out_ready,
    output gnt, sel, y, y_valid, busy
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin 8:1 bit-mux scheduler: one-cycle arbitration from IDLE, back-to-back re-grant on release.
// A grant lasts up to MAX_BURST accepted beats; out_ready=0 stalls the beat count and holds the grant.
module mux_rr_scheduler #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_scheduler_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       granted;
  logic       beat;
  logic       last_beat;
  logic       release_grant;
  logic [2:0] scan_start;
  logic [2:0] cand;
  logic       win_vld;
  logic [2:0] win_idx;

  assign granted       = (state_q == GRANT);
  assign bus.y_valid   = granted & bus.req[sel_q];
  assign bus.y         = bus.y_valid & bus.din[sel_q];
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = granted;

  assign beat          = bus.y_valid & bus.out_ready;
  assign last_beat     = beat && (cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_grant = !bus.req[sel_q] || last_beat;

  // Scanning from sel+1 puts the current holder last, so it only wins when alone.
  assign scan_start = granted ? (sel_q + 3'd1) : ptr_q;

  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    cand    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = scan_start + 3'(i);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          sel_d   = win_idx;
          gnt_d   = 8'b1 << win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_d = sel_q + 3'd1;
          cnt_d = '0;
          if (win_vld) begin
            sel_d = win_idx;
            gnt_d = 8'b1 << win_idx;
          end else begin
            gnt_d   = 8'h00;
            state_d = IDLE;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler with hand-computed expectations (MAX_BURST=4).
module tb_mux_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mux_rr_scheduler_if bus ();

  mux_rr_scheduler #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req       = 8'h00;
    bus.din       = 8'h00;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.req = 8'h00; bus.din = 8'h00; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL rst_gnt got %h exp 00", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL rst_yvalid got %b exp 0", bus.y_valid); end
    n_cmp++; if (bus.sel !== 3'd0) begin n_err++; $display("FAIL rst_sel got %0d exp 0", bus.sel); end
    rst = 1'b0;
    bus.req = 8'hFF; bus.din = 8'hFF; bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.gnt !== 8'h01) begin n_err++; $display("FAIL first_gnt got %h exp 01", bus.gnt); end
    tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL midrst_gnt got %h exp 00", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL midrst_yvalid got %b exp 0", bus.y_valid); end
    n_cmp++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL midrst_y got %b exp 0", bus.y); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL postrst_busy got %b exp 0", bus.busy); end
    tick();
    n_cmp++; if (bus.gnt !== 8'h01) begin n_err++; $display("FAIL postrst_gnt got %h exp 01", bus.gnt); end
    n_cmp++; if (bus.sel !== 3'd0) begin n_err++; $display("FAIL postrst_sel got %0d exp 0", bus.sel); end
  endtask

  task automatic test_single_burst();
    do_reset();
    bus.req = 8'h08; bus.din = 8'h08; bus.out_ready = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (bus.gnt !== 8'h08 || bus.sel !== 3'd3) begin n_err++; $display("FAIL single_gnt c=%0d got gnt=%h sel=%0d exp gnt=08 sel=3", c, bus.gnt, bus.sel); end
      n_cmp++; if (bus.y_valid !== 1'b1 || bus.y !== 1'b1) begin n_err++; $display("FAIL single_y c=%0d got y_valid=%b y=%b exp 1 1", c, bus.y_valid, bus.y); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_gnt;
    do_reset();
    bus.req = 8'h81; bus.din = 8'h00; bus.out_ready = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      exp_gnt = (((c / 4) % 2) == 0) ? 8'h01 : 8'h80;
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt c=%0d got %h exp %h", c, bus.gnt, exp_gnt); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] rdy_pat;
    rdy_pat = 6'b111001;
    do_reset();
    bus.req = 8'h24; bus.din = 8'h04; bus.out_ready = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      bus.out_ready = rdy_pat[c];
      #1;
      n_cmp++; if (bus.gnt !== 8'h04) begin n_err++; $display("FAIL bp_gnt c=%0d got %h exp 04", c, bus.gnt); end
      n_cmp++; if (bus.y_valid !== 1'b1) begin n_err++; $display("FAIL bp_yvalid c=%0d got %b exp 1", c, bus.y_valid); end
      tick();
    end
    n_cmp++; if (bus.gnt !== 8'h20 || bus.sel !== 3'd5) begin n_err++; $display("FAIL bp_release got gnt=%h sel=%0d exp gnt=20 sel=5", bus.gnt, bus.sel); end
  endtask

  task automatic test_early_drop();
    do_reset();
    bus.req = 8'h20; bus.din = 8'hFF; bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.gnt !== 8'h20) begin n_err++; $display("FAIL drop_gnt5 got %h exp 20", bus.gnt); end
    bus.req = 8'h24;
    tick(); tick();
    bus.req = 8'h04;
    #1;
    n_cmp++; if (bus.y_valid !== 1'b0 || bus.y !== 1'b0) begin n_err++; $display("FAIL drop_yvalid got y_valid=%b y=%b exp 0 0", bus.y_valid, bus.y); end
    n_cmp++; if (bus.gnt !== 8'h20 || bus.busy !== 1'b1) begin n_err++; $display("FAIL drop_hold got gnt=%h busy=%b exp 20 1", bus.gnt, bus.busy); end
    tick();
    n_cmp++; if (bus.gnt !== 8'h04 || bus.sel !== 3'd2) begin n_err++; $display("FAIL drop_regrant got gnt=%h sel=%0d exp 04 2", bus.gnt, bus.sel); end
  endtask

  task automatic test_datapath();
    logic [7:0] din_v [6];
    logic       y_v   [6];
    din_v = '{8'h40, 8'h00, 8'hBF, 8'hFF, 8'h3F, 8'h40};
    y_v   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus.req = 8'h40; bus.out_ready = 1'b0;
    tick();
    n_cmp++; if (bus.gnt !== 8'h40 || bus.sel !== 3'd6) begin n_err++; $display("FAIL dp_gnt got gnt=%h sel=%0d exp 40 6", bus.gnt, bus.sel); end
    for (int v = 0; v < 6; v++) begin
      bus.din = din_v[v];
      #1;
      n_cmp++; if (bus.y !== y_v[v]) begin n_err++; $display("FAIL dp_y v=%0d din=%h got %b exp %b", v, din_v[v], bus.y, y_v[v]); end
    end
    bus.req = 8'h00;
    tick();
    bus.din = 8'hFF;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00) begin n_err++; $display("FAIL dp_idle got busy=%b gnt=%h exp 0 00", bus.busy, bus.gnt); end
    n_cmp++; if (bus.y !== 1'b0 || bus.y_valid !== 1'b0) begin n_err++; $display("FAIL dp_idle_y got y=%b y_valid=%b exp 0 0", bus.y, bus.y_valid); end
    n_cmp++; if (bus.sel !== 3'd6) begin n_err++; $display("FAIL dp_idle_sel got %0d exp 6", bus.sel); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_early_drop();
    test_datapath();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
